// File: rtl/nav_jump_sequencer.sv
// nav_jump_sequencer: drives the position datapath mode through init, cruise, jump charge, jump and cooldown
module nav_jump_sequencer #(
    parameter int k               = 16,
    parameter int CHARGE_CYCLES   = 8,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CW              = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_req,
    input  logic [3*k-1:0]   jump_target,
    input  logic [3:0]       ship_mode,
    input  logic             abort,
    output logic [3:0]       pos_mode,
    output logic [3*k-1:0]   jump_position,
    output logic             jump_ack,
    output logic             jump_done,
    output logic             jump_abort,
    output logic             busy
);
    typedef enum logic [2:0] {INIT, CRUISE, CHARGE, JUMP, COOLDOWN} state_t;
    localparam logic [CW-1:0] ONE = CW'(1);
    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next, charge_len;
    logic [3*k-1:0] position_next;
    logic mode_ok, accept, ack_next, done_next, abort_next;
    // ship mode decode: legal jump modes and their charge length
    always_comb begin
        mode_ok    = ship_mode inside {4'b0010, 4'b0100, 4'b1000};
        charge_len = ship_mode == 4'b1000 ? CW'(4 * CHARGE_CYCLES) :
                     ship_mode == 4'b0100 ? CW'(2 * CHARGE_CYCLES) : CW'(CHARGE_CYCLES);
        accept     = state == CRUISE && jump_req && !abort && mode_ok;
    end
    // next-state, counter, target latch and pulse flags
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        position_next = jump_position;
        ack_next      = 1'b0;
        done_next     = 1'b0;
        abort_next    = 1'b0;
        case (state)
            INIT: state_next = CRUISE;
            CRUISE: if (accept) begin
                state_next    = CHARGE;
                cnt_next      = charge_len - ONE;
                position_next = jump_target;
                ack_next      = 1'b1;
            end
            CHARGE: if (abort) begin
                state_next = CRUISE;
                abort_next = 1'b1;
            end else if (cnt == '0) begin
                state_next = JUMP;
            end else begin
                cnt_next = cnt - ONE;
            end
            JUMP: begin
                state_next = COOLDOWN;
                cnt_next   = CW'(COOLDOWN_CYCLES - 1);
                done_next  = 1'b1;
            end
            COOLDOWN: if (cnt == '0) state_next = CRUISE;
                      else cnt_next = cnt - ONE;
            default: state_next = INIT;
        endcase
    end
    // state, counter, latched target and one-cycle pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            cnt           <= '0;
            jump_position <= '0;
            jump_ack      <= 1'b0;
            jump_done     <= 1'b0;
            jump_abort    <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            jump_position <= position_next;
            jump_ack      <= ack_next;
            jump_done     <= done_next;
            jump_abort    <= abort_next;
        end
    end
    // datapath select and busy decoded from the registered state
    always_comb begin
        pos_mode = state == INIT ? 4'b0001 : state == JUMP ? 4'b0100 : 4'b0010;
        busy     = state != CRUISE;
    end
endmodule

// File: tb/tb_nav_jump_sequencer.sv
// tb_nav_jump_sequencer: table vectors plus directed sequences for the jump sequencer
module tb_nav_jump_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jump_req = 1'b0;
    logic [47:0] jump_target = '0;
    logic [3:0] ship_mode = 4'b0001;
    logic abort = 1'b0;
    logic [3:0] pos_mode;
    logic [47:0] jump_position;
    logic jump_ack, jump_done, jump_abort, busy;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        req;
        logic [3:0]  mode;
        logic        ab;
        logic [47:0] tgt;
        logic [3:0]  e_pm;
        logic        e_ack, e_done, e_abt, e_busy;
        logic [47:0] e_pos;
    } vec_t;
    vec_t vecs[$];

    localparam logic [47:0] T1 = {16'd3, 16'd2, 16'd1};
    localparam logic [47:0] T2 = {16'd7, 16'd7, 16'd7};
    localparam logic [47:0] T3 = {16'd9, 16'd8, 16'd7};

    nav_jump_sequencer dut (
        .clk(clk), .rst(rst), .jump_req(jump_req), .jump_target(jump_target),
        .ship_mode(ship_mode), .abort(abort), .pos_mode(pos_mode),
        .jump_position(jump_position), .jump_ack(jump_ack), .jump_done(jump_done),
        .jump_abort(jump_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] pm, input logic ack,
                              input logic done, input logic abt, input logic bsy, input logic [47:0] pos);
        check({name, "_pos_mode"}, 64'(pos_mode), 64'(pm));
        check({name, "_ack"}, 64'(jump_ack), 64'(ack));
        check({name, "_done"}, 64'(jump_done), 64'(done));
        check({name, "_abort"}, 64'(jump_abort), 64'(abt));
        check({name, "_busy"}, 64'(busy), 64'(bsy));
        check({name, "_position"}, 64'(jump_position), 64'(pos));
    endtask

    function automatic void add(input logic req, input logic [3:0] mode, input logic ab, input logic [47:0] tgt,
                                input logic [3:0] pm, input logic ack, input logic done, input logic abt,
                                input logic bsy, input logic [47:0] pos);
        vec_t v;
        v.req = req; v.mode = mode; v.ab = ab; v.tgt = tgt;
        v.e_pm = pm; v.e_ack = ack; v.e_done = done; v.e_abt = abt; v.e_busy = bsy; v.e_pos = pos;
        vecs.push_back(v);
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic jump_latency(input string name, input logic [3:0] mode, input int lat, input bit switch_mode);
        int n;
        logic ack0;
        jump_req = 1'b1;
        ship_mode = mode;
        jump_target = T2;
        step();
        jump_req = 1'b0;
        ack0 = jump_ack;
        n = 1;
        while (pos_mode != 4'b0100 && n < 100) begin
            if (switch_mode && n == 5) ship_mode = 4'b0010;
            step();
            n++;
        end
        check({name, "_ack"}, 64'(ack0), 64'(1));
        check({name, "_latency"}, 64'(n), 64'(lat));
        step();
        check({name, "_done"}, 64'(jump_done), 64'(1));
        wait_idle(name);
    endtask

    initial begin
        int n;
        bit saw_jump, saw_pulse;
        // ATTACK jump, one row per cycle; target changes after acceptance must be ignored
        add(1, 4'b0010, 0, T1, 4'b0010, 1, 0, 0, 1, T1);
        for (int i = 1; i < 8; i++) add(0, 4'b0010, 0, T2, 4'b0010, 0, 0, 0, 1, T1);
        add(0, 4'b0010, 0, T2, 4'b0100, 0, 0, 0, 1, T1);
        add(0, 4'b0010, 0, T2, 4'b0010, 0, 1, 0, 1, T1);
        for (int i = 0; i < 3; i++) add(0, 4'b0010, 0, T2, 4'b0010, 0, 0, 0, 1, T1);
        add(0, 4'b0010, 0, T2, 4'b0010, 0, 0, 0, 0, T1);

        #1;
        for (int i = 0; i < 3; i++) begin
            check_outs($sformatf("reset%0d", i), 4'b0001, 0, 0, 0, 1, '0);
            step();
        end
        rst = 1'b0;
        #1;
        check_outs("init", 4'b0001, 0, 0, 0, 1, '0);
        step();
        check_outs("cruise", 4'b0010, 0, 0, 0, 0, '0);

        foreach (vecs[i]) begin
            jump_req = vecs[i].req;
            ship_mode = vecs[i].mode;
            abort = vecs[i].ab;
            jump_target = vecs[i].tgt;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_pm, vecs[i].e_ack, vecs[i].e_done,
                       vecs[i].e_abt, vecs[i].e_busy, vecs[i].e_pos);
        end

        jump_latency("defense", 4'b0100, 17, 1'b1);
        jump_latency("stealth", 4'b1000, 33, 1'b1);

        // abort on the 5th charge edge
        jump_req = 1'b1;
        ship_mode = 4'b0010;
        jump_target = T3;
        step();
        jump_req = 1'b0;
        jump_target = T1;
        saw_jump = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw_jump |= pos_mode == 4'b0100;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("abort", 4'b0010, 0, 0, 1, 0, T3);
        for (int i = 0; i < 12; i++) begin
            step();
            saw_jump |= pos_mode == 4'b0100;
        end
        check("abort_no_jump", 64'(saw_jump), 64'(0));
        check_outs("abort_after", 4'b0010, 0, 0, 0, 0, T3);

        // zero-speed mode never accepted
        ship_mode = 4'b0001;
        jump_req = 1'b1;
        jump_target = T1;
        saw_pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            saw_pulse |= jump_ack | busy;
        end
        check("reject_zero_speed", 64'(saw_pulse), 64'(0));
        ship_mode = 4'b0010;
        step();
        check("reject_then_ack", 64'(jump_ack), 64'(1));
        // request held through cooldown: re-accepted only after cruise returns
        n = 1;
        step();
        n++;
        while (!jump_ack && n < 100) begin
            step();
            n++;
        end
        check("held_req_reaccept", 64'(n), 64'(15));
        jump_req = 1'b0;
        wait_idle("held_req");

        // asynchronous reset with counter at 3
        jump_req = 1'b1;
        step();
        jump_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #3 rst = 1'b1;
        #1;
        check_outs("async_rst", 4'b0001, 0, 0, 0, 1, '0);
        saw_pulse = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            saw_pulse |= jump_ack | jump_done | jump_abort | (pos_mode != 4'b0001);
        end
        check("async_rst_hold", 64'(saw_pulse), 64'(0));
        rst = 1'b0;
        #1;
        check_outs("async_init", 4'b0001, 0, 0, 0, 1, '0);
        step();
        check_outs("async_cruise", 4'b0010, 0, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nav_jump_sequencer.md
# nav_jump_sequencer

Sequencer that owns the `pos_mode` select of the three-axis position datapath. It holds the datapath in reset after power-up, then in normal (sublight) integration. It accepts jump requests through a req/ack handshake and charges for a mode-dependent time. It then drives exactly one jump cycle that loads the latched target into all three axis registers, and enforces a cooldown before the next request can be accepted. It sits between the ship command logic (requester, ship mode) and the position/velocity datapath.

## Interface
- `k`, 16, per-axis position width
- `CHARGE_CYCLES`, 8, base charge length in cycles (ATTACK mode); must be ≥1
- `COOLDOWN_CYCLES`, 4, cycles after a jump before the next request is accepted; must be ≥1
- `CW`, 8, counter width; must hold 4*CHARGE_CYCLES and COOLDOWN_CYCLES
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `jump_req` input 1: level request, held until `jump_ack`
- `jump_target` input 3k: {Z,Y,X} target; valid while `jump_req` is high
- `ship_mode` input 4: one-hot; 0010 ATTACK, 0100 DEFENSE, 1000 STEALTH; 0001 means zero speed
- `abort` input 1: cancels a jump that is still charging
- `pos_mode` output 4: one-hot datapath select; 0001 RESET, 0010 NORMAL, 0100 JUMP
- `jump_position` output 3k: latched target, feeds the datapath jump input
- `jump_ack` output 1: one-cycle pulse, request accepted
- `jump_done` output 1: one-cycle pulse, jump has been applied
- `jump_abort` output 1: one-cycle pulse, charge was cancelled
- `busy` output 1: high in every state except CRUISE

## Operation
- States: INIT, CRUISE, CHARGE, JUMP, COOLDOWN. Moore outputs, decoded from registered state and flags.
- `pos_mode` by state:
  - INIT → 0001
  - JUMP → 0100
  - CRUISE, CHARGE, COOLDOWN → 0010
  - 1000 is never driven.
- While `rst` is high:
  - state = INIT, `pos_mode`=0001, `jump_position`=0, counter=0.
  - All pulses = 0, `busy`=1.
- INIT lasts exactly one cycle after `rst` deasserts, then moves to CRUISE.
- CRUISE: a request is accepted on an edge where all of the following hold: `jump_req`=1, `abort`=0, and `ship_mode` is exactly 0010, 0100 or 1000. Otherwise it is not accepted and `jump_req` stays pending.
- On acceptance, at the same edge:
  - latch `jump_target` into `jump_position`;
  - latch the charge length L = CHARGE_CYCLES × {1, 2, 4} for ATTACK / DEFENSE / STEALTH;
  - load the counter with L−1 and go to CHARGE;
  - `jump_ack`=1 during the first CHARGE cycle.
- After acceptance, `ship_mode` and `jump_target` changes are ignored until the next acceptance.
- CHARGE lasts L cycles, decrementing the counter. When counter=0 the next state is JUMP.
- `abort`=1 on any CHARGE edge:
  - next state is CRUISE;
  - `jump_abort`=1 during that first CRUISE cycle;
  - no jump is issued and `jump_position` is held.
  - `abort` has priority over the counter reaching 0.
- JUMP lasts exactly one cycle (`pos_mode`=0100). The axis registers load `jump_position` at the end of this cycle.
- COOLDOWN:
  - counter loads COOLDOWN_CYCLES−1 on entry and lasts COOLDOWN_CYCLES cycles;
  - `jump_done`=1 during its first cycle;
  - `jump_req` and `abort` are ignored; the next state is CRUISE.
- `jump_position` changes only on acceptance or reset.
- Counter arithmetic is unsigned CW-bit; it never wraps in legal configurations.

## Timing
- Reset asserted mid-operation (any state): all outputs go to their reset values immediately (asynchronous). No pulse is emitted and no partial jump occurs.
- Let acceptance occur at edge E0. Then:
  - CHARGE occupies cycles E0+1 … E0+L;
  - JUMP occupies cycle E0+L+1;
  - `jump_done` is high in cycle E0+L+2;
  - CRUISE is re-entered at cycle E0+L+COOLDOWN_CYCLES+2.
- Request-to-jump latency is L+1 cycles.
- The earliest possible next acceptance is at the edge that ends the first CRUISE cycle.
- A `jump_req` still high after `jump_ack` (requester slow to drop it) is treated as a new request once CRUISE is re-entered.
- Pulses are never high together:
  - `jump_ack` is only in the first CHARGE cycle;
  - `jump_abort` is only in the first CRUISE cycle after an abort;
  - `jump_done` is only in the first COOLDOWN cycle.

## Test plan
- Reset release: hold `rst` 3 cycles, then release. Expect:
  - `pos_mode`=0001 during reset and for 1 cycle after release;
  - then 0010, with `busy` low;
  - all pulses 0 throughout.
- ATTACK jump: `ship_mode`=0010, `jump_target`={3,2,1}, `jump_req` pulsed with defaults. Expect:
  - `jump_ack` at E0+1;
  - `pos_mode`=0100 only at E0+9;
  - `jump_done` at E0+10;
  - CRUISE at E0+14;
  - `jump_position`={3,2,1}.
- STEALTH/DEFENSE charge: `ship_mode`=1000 gives JUMP at E0+33; `ship_mode`=0100 gives JUMP at E0+17. Change `ship_mode` to 0010 mid-charge → no change in timing.
- Abort: assert `abort` at the 5th CHARGE edge. Expect:
  - `jump_abort` pulse next cycle, state CRUISE;
  - no 0100 on `pos_mode`;
  - `jump_position` retains the latched target.
- Rejection:
  - `ship_mode`=0001, `jump_req`=1 for 10 cycles → no ack; then `ship_mode`=0010 → ack on the next cycle.
  - `jump_req` high throughout COOLDOWN → ack only after CRUISE is re-entered.
- Async reset during CHARGE (counter=3): `pos_mode`=0001 immediately, with no `jump_done` or `jump_abort` pulse. After release, INIT then CRUISE.
